window_gen: RTL and testbench

- Streaming KxK sliding-window generator for the convolution datapath.
- Accepts raster-order pixels over a valid/ready handshake and stores FILTER_SIZE-1 rows in line buffers plus a KxK column shift array.
- Emits one flattened window per qualifying output position, with configurable pixel width and stride, under full backpressure.
- Sits between the pixel source (image RAM/DMA) and the convolve MAC stage. It replaces the buffer-indexed window extractor, so the upstream no longer has to deliver whole FILTER_SIZE-row buffers.

---
 rtl/conv_pkg.sv | 23 ++
 rtl/line_buffer.sv | 34 +++
 rtl/window_gen.sv | 177 +++++++++++++++++
 tb/tb_window_gen.sv | 441 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// conv_pkg: definitions shared by the convolution datapath blocks.
//   cnt_width(dim)      - bits needed to count 0..dim-1 (at least 1)
//   win_width(k, pw)    - bits in a flattened k x k window of pw-bit pixels
//   win_idx(r, c, k)    - element slot of window element (r,c) in the flat vector
//   DEFAULT_FILTER_SIZE - window edge shared by window_gen and convolve
package conv_pkg;

    localparam int DEFAULT_FILTER_SIZE = 3;

    function automatic int cnt_width(input int dim);
        return (dim > 1) ? $clog2(dim) : 1;
    endfunction

    function automatic int win_width(input int k, input int pw);
        return k * k * pw;
    endfunction

    // Element (r,c) lives at bits [win_idx(r,c,k)*pw +: pw]; r=0 is the oldest row.
    function automatic int win_idx(input int r, input int c, input int k);
        return r * k + c;
    endfunction

endpackage

// File: rtl/line_buffer.sv
// line_buffer: single-row delay memory. Each word holds the K-1 previous rows'
// pixels for one column. Read and write share one address; the read is
// combinational, so it returns the word as it was before this cycle's write.
//   clk     - clock
//   wr_en   - write the word at addr on this edge
//   addr    - column address
//   wr_data - new word for addr
//   rd_data - current (pre-write) word at addr
module line_buffer
    import conv_pkg::*;
#(
    parameter int DEPTH = 128,
    parameter int WIDTH = 16
) (
    input  logic                        clk,
    input  logic                        wr_en,
    input  logic [cnt_width(DEPTH)-1:0] addr,
    input  logic [WIDTH-1:0]            wr_data,
    output logic [WIDTH-1:0]            rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    // NOTE: storage arrays get no reset; a reset would block RAM inference and
    // stale words are always overwritten before they can reach the output.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[addr] <= wr_data;
        end
    end

    assign rd_data = mem[addr];

endmodule

// File: rtl/window_gen.sv
// window_gen: streaming KxK sliding-window generator.
// Raster-order pixels arrive on a valid/ready handshake; K-1 rows are held in a
// line buffer and the current KxK neighbourhood in a column shift array. Each
// accepted pixel that completes a stride-aligned window produces one registered
// window one cycle later.
//   clk, rst               - clock, synchronous active-high reset
//   pix_in/pix_valid       - input pixel stream
//   pix_ready              - pixel accepted this cycle when pix_valid is high
//   window_out             - flattened window, element (r,c) at (r*K+c)*PIXEL_WIDTH
//   window_valid/ready     - output handshake
//   win_row/win_col        - top-left coordinate of window_out
//   frame_done             - one-cycle pulse after the last pixel of a frame
module window_gen
    import conv_pkg::*;
#(
    parameter int IMAGE_WIDTH  = 128,
    parameter int IMAGE_HEIGHT = 128,
    parameter int FILTER_SIZE  = DEFAULT_FILTER_SIZE,
    parameter int PIXEL_WIDTH  = 8,
    parameter int STRIDE       = 1
) (
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic [PIXEL_WIDTH-1:0]                        pix_in,
    input  logic                                          pix_valid,
    output logic                                          pix_ready,
    output logic [win_width(FILTER_SIZE, PIXEL_WIDTH)-1:0] window_out,
    output logic                                          window_valid,
    input  logic                                          window_ready,
    output logic [cnt_width(IMAGE_HEIGHT)-1:0]            win_row,
    output logic [cnt_width(IMAGE_WIDTH)-1:0]             win_col,
    output logic                                          frame_done
);

    localparam int K  = FILTER_SIZE;
    localparam int PW = PIXEL_WIDTH;
    localparam int RW = cnt_width(IMAGE_HEIGHT);
    localparam int CW = cnt_width(IMAGE_WIDTH);
    localparam int SW = cnt_width(STRIDE);

    localparam logic [CW-1:0] COL_LAST  = CW'(IMAGE_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST  = RW'(IMAGE_HEIGHT - 1);
    localparam logic [CW-1:0] COL_FIRST = CW'(K - 1);
    localparam logic [RW-1:0] ROW_FIRST = RW'(K - 1);
    localparam logic [SW-1:0] S_RELOAD  = SW'(STRIDE - 1);

    logic [CW-1:0] col;
    logic [RW-1:0] row;
    // Stride phase down-counters: zero means this column/row is on the stride grid.
    logic [SW-1:0] x_cnt;
    logic [SW-1:0] y_cnt;

    logic [PW-1:0] win_q    [K][K];
    logic [PW-1:0] win_next [K][K];
    logic [win_width(K, PW)-1:0] win_flat;

    logic [(K-1)*PW-1:0] lb_rd;
    logic [(K-1)*PW-1:0] lb_wr;

    logic accept;
    logic col_last;
    logic row_last;
    logic col_hit;
    logic row_hit;
    logic qualify;

    assign pix_ready = !window_valid || window_ready;
    assign accept    = pix_valid && pix_ready;
    assign col_last  = (col == COL_LAST);
    assign row_last  = (row == ROW_LAST);
    assign col_hit   = (col >= COL_FIRST) && (x_cnt == '0);
    assign row_hit   = (row >= ROW_FIRST) && (y_cnt == '0);
    assign qualify   = accept && col_hit && row_hit;

    line_buffer #(
        .DEPTH (IMAGE_WIDTH),
        .WIDTH ((K - 1) * PW)
    ) u_line_buffer (
        .clk     (clk),
        .wr_en   (accept),
        .addr    (col),
        .wr_data (lb_wr),
        .rd_data (lb_rd)
    );

    // Column taps: slot r of the line-buffer word is row (row-(K-1)+r); the
    // incoming pixel is the newest row. The word written back drops the oldest
    // row and appends pix_in.
    // NOTE: every always_comb output is given a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        lb_wr = '0;
        for (int r = 0; r < K; r++) begin
            for (int c = 0; c < K; c++) begin
                win_next[r][c] = win_q[r][c];
            end
        end
        for (int r = 0; r < K; r++) begin
            for (int c = 0; c < K - 1; c++) begin
                win_next[r][c] = win_q[r][c+1];
            end
        end
        for (int r = 0; r < K - 1; r++) begin
            win_next[r][K-1] = lb_rd[r*PW +: PW];
        end
        win_next[K-1][K-1] = pix_in;
        for (int r = 0; r < K - 2; r++) begin
            lb_wr[r*PW +: PW] = lb_rd[(r+1)*PW +: PW];
        end
        lb_wr[(K-2)*PW +: PW] = pix_in;
    end

    always_comb begin
        win_flat = '0;
        for (int r = 0; r < K; r++) begin
            for (int c = 0; c < K; c++) begin
                win_flat[win_idx(r, c, K)*PW +: PW] = win_next[r][c];
            end
        end
    end

    // Shift array holds only pixel data that is fully refilled before any
    // qualifying column, so it carries no reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            win_q <= win_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col          <= '0;
            row          <= '0;
            x_cnt        <= '0;
            y_cnt        <= '0;
            window_valid <= 1'b0;
            window_out   <= '0;
            win_row      <= '0;
            win_col      <= '0;
            frame_done   <= 1'b0;
        end else begin
            frame_done <= accept && col_last && row_last;

            if (accept) begin
                if (col_last) begin
                    col   <= '0;
                    x_cnt <= '0;
                    if (row_last) begin
                        row   <= '0;
                        y_cnt <= '0;
                    end else begin
                        row <= row + RW'(1);
                        if (row >= ROW_FIRST) begin
                            y_cnt <= (y_cnt == '0) ? S_RELOAD : y_cnt - SW'(1);
                        end
                    end
                end else begin
                    col <= col + CW'(1);
                    if (col >= COL_FIRST) begin
                        x_cnt <= (x_cnt == '0) ? S_RELOAD : x_cnt - SW'(1);
                    end
                end
            end

            // A new window overrides the handshake clear, keeping the stream bubble-free.
            if (qualify) begin
                window_valid <= 1'b1;
                window_out   <= win_flat;
                win_row      <= row - ROW_FIRST;
                win_col      <= col - COL_FIRST;
            end else if (window_ready) begin
                window_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_window_gen.sv
// Self-checking bench for window_gen. Four instances cover the configurations
// of interest; one is active at a time. A monitor scores every transferred
// window against a queue filled by a direct-indexing image model.
module tb_window_gen;

    typedef struct {
        int           row;
        int           col;
        logic [299:0] data;
    } win_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [11:0] pix;
    logic [3:0]  vld;
    logic        wready;

    logic [71:0]  wo_a, wo_b, wo_c;
    logic [1:0]   wr_a, wc_a;
    logic [2:0]   wr_b, wc_b, wr_c, wc_c, wr_d, wc_d;
    logic [299:0] wo [4];
    int           wrow [4];
    int           wcol [4];
    logic         wv [4];
    logic         fd [4];
    logic         pr [4];

    always #5 clk = ~clk;

    window_gen #(.IMAGE_WIDTH(4), .IMAGE_HEIGHT(4), .FILTER_SIZE(3), .PIXEL_WIDTH(8), .STRIDE(1)) dut_a (
        .clk(clk), .rst(rst), .pix_in(pix[7:0]), .pix_valid(vld[0]), .pix_ready(pr[0]),
        .window_out(wo_a), .window_valid(wv[0]), .window_ready(wready),
        .win_row(wr_a), .win_col(wc_a), .frame_done(fd[0]));

    window_gen #(.IMAGE_WIDTH(6), .IMAGE_HEIGHT(6), .FILTER_SIZE(3), .PIXEL_WIDTH(8), .STRIDE(2)) dut_b (
        .clk(clk), .rst(rst), .pix_in(pix[7:0]), .pix_valid(vld[1]), .pix_ready(pr[1]),
        .window_out(wo_b), .window_valid(wv[1]), .window_ready(wready),
        .win_row(wr_b), .win_col(wc_b), .frame_done(fd[1]));

    window_gen #(.IMAGE_WIDTH(8), .IMAGE_HEIGHT(8), .FILTER_SIZE(3), .PIXEL_WIDTH(8), .STRIDE(1)) dut_c (
        .clk(clk), .rst(rst), .pix_in(pix[7:0]), .pix_valid(vld[2]), .pix_ready(pr[2]),
        .window_out(wo_c), .window_valid(wv[2]), .window_ready(wready),
        .win_row(wr_c), .win_col(wc_c), .frame_done(fd[2]));

    window_gen #(.IMAGE_WIDTH(7), .IMAGE_HEIGHT(5), .FILTER_SIZE(5), .PIXEL_WIDTH(12), .STRIDE(1)) dut_d (
        .clk(clk), .rst(rst), .pix_in(pix), .pix_valid(vld[3]), .pix_ready(pr[3]),
        .window_out(wo[3]), .window_valid(wv[3]), .window_ready(wready),
        .win_row(wr_d), .win_col(wc_d), .frame_done(fd[3]));

    assign wo[0] = {228'd0, wo_a};
    assign wo[1] = {228'd0, wo_b};
    assign wo[2] = {228'd0, wo_c};
    assign wrow[0] = int'(wr_a);
    assign wcol[0] = int'(wc_a);
    assign wrow[1] = int'(wr_b);
    assign wcol[1] = int'(wc_b);
    assign wrow[2] = int'(wr_c);
    assign wcol[2] = int'(wc_c);
    assign wrow[3] = int'(wr_d);
    assign wcol[3] = int'(wc_d);

    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   act = 0;
    bit   mon_en = 0;
    bit   rand_mode = 0;
    int   first_valid_cyc = -1;
    int   fd_cnt = 0;
    int   img [$];
    win_t exp_q [$];
    win_t obs_q [$];

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: handshake rule, hold-under-backpressure, and in-order scoreboard.
    bit           stall_prev = 0;
    logic [299:0] prev_wo;
    int           prev_r, prev_c;
    always @(negedge clk) begin
        if (!rst && mon_en) begin
            checks++;
            if (pr[act] !== (!wv[act] || wready)) begin
                errors++;
                $display("FAIL pix_ready dut%0d cyc %0d: got %b want %b", act, cyc, pr[act], !wv[act] || wready);
            end
            if (stall_prev) begin
                checks++;
                if (wv[act] !== 1'b1 || wo[act] !== prev_wo || wrow[act] != prev_r || wcol[act] != prev_c) begin
                    errors++;
                    $display("FAIL hold dut%0d cyc %0d: got v=%b (%0d,%0d) %h want v=1 (%0d,%0d) %h",
                             act, cyc, wv[act], wrow[act], wcol[act], wo[act], prev_r, prev_c, prev_wo);
                end
            end
            if (wv[act] === 1'b1 && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (wv[act] === 1'b1 && wready) begin
                win_t o;
                o.row  = wrow[act];
                o.col  = wcol[act];
                o.data = wo[act];
                obs_q.push_back(o);
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL window dut%0d: got unexpected (%0d,%0d) %h, want none", act, o.row, o.col, o.data);
                end else begin
                    win_t e;
                    e = exp_q.pop_front();
                    if (e.row != o.row || e.col != o.col || e.data !== o.data) begin
                        errors++;
                        $display("FAIL window dut%0d: got (%0d,%0d) %h, want (%0d,%0d) %h",
                                 act, o.row, o.col, o.data, e.row, e.col, e.data);
                    end
                end
            end
            if (fd[act] === 1'b1) fd_cnt++;
            stall_prev = (wv[act] === 1'b1) && !wready;
            prev_wo    = wo[act];
            prev_r     = wrow[act];
            prev_c     = wcol[act];
        end else begin
            stall_prev = 0;
        end
    end

    // Reference model: every stride-aligned KxK window read straight from the image.
    task automatic gen_expected(input int h, input int w, input int k, input int s, input int pw, input int base);
        for (int wr = 0; wr <= h - k; wr += s) begin
            for (int wc = 0; wc <= w - k; wc += s) begin
                win_t e;
                e.row  = wr;
                e.col  = wc;
                e.data = '0;
                for (int r = 0; r < k; r++) begin
                    for (int c = 0; c < k; c++) begin
                        logic [299:0] p;
                        p = 300'(img[base + (wr + r) * w + wc + c]);
                        e.data = e.data | (p << ((r * k + c) * pw));
                    end
                end
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic step_ready();
        wready = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    endtask

    task automatic send_pix(input logic [11:0] v, output int acc_at);
        bit got = 0;
        pix = v;
        vld[act] = 1'b1;
        acc_at = -1;
        for (int t = 0; t < 200 && !got; t++) begin
            bit r;
            @(negedge clk);
            r = pr[act];
            @(posedge clk);
            #1;
            step_ready();
            if (r) begin
                got = 1;
                acc_at = cyc;
            end
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout dut%0d: got no accept, want accept within 200 cycles", act);
        end
    endtask

    task automatic drain();
        bit done = 0;
        vld = '0;
        for (int t = 0; t < 200 && !done; t++) begin
            @(negedge clk);
            if (wv[act] !== 1'b1) done = 1;
            else begin
                @(posedge clk);
                #1;
                step_ready();
            end
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout dut%0d: got window_valid stuck, want 0 within 200 cycles", act);
        end
        repeat (3) begin
            @(posedge clk);
            #1;
            step_ready();
        end
    endtask

    task automatic start_test(input int d);
        act = d;
        exp_q.delete();
        obs_q.delete();
        img.delete();
        first_valid_cyc = -1;
        fd_cnt = 0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 4; d++) begin
            checks++;
            if (wv[d] !== 1'b0 || wo[d] !== '0 || wrow[d] != 0 || wcol[d] != 0 || fd[d] !== 1'b0 || pr[d] !== 1'b1) begin
                errors++;
                $display("FAIL reset_state dut%0d: got v=%b out=%h (%0d,%0d) fd=%b rdy=%b, want all 0 and rdy=1",
                         d, wv[d], wo[d], wrow[d], wcol[d], fd[d], pr[d]);
            end
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        mon_en = 1;
    endtask

    task automatic test_ramp4();
        int acc, acc10;
        int fw[9] = '{0, 1, 2, 4, 5, 6, 8, 9, 10};
        logic [299:0] want;
        start_test(0);
        for (int i = 0; i < 16; i++) img.push_back(i);
        gen_expected(4, 4, 3, 1, 8, 0);
        acc10 = -1;
        for (int i = 0; i < 16; i++) begin
            send_pix(12'(img[i]), acc);
            if (i == 10) acc10 = acc;
        end
        drain();
        want = '0;
        for (int i = 0; i < 9; i++) want = want | (300'(fw[i]) << (i * 8));
        checks++;
        if (obs_q.size() != 4 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL ramp4_count: got %0d windows (%0d missing), want 4", obs_q.size(), exp_q.size());
        end
        checks++;
        if (obs_q.size() == 0 || obs_q[0].data !== want) begin
            errors++;
            $display("FAIL ramp4_first: got %0d windows / first differs, want %h", obs_q.size(), want);
        end
        checks++;
        if (first_valid_cyc != acc10) begin
            errors++;
            $display("FAIL ramp4_latency: got valid at cycle %0d, want %0d", first_valid_cyc, acc10);
        end
        checks++;
        if (fd_cnt != 1) begin
            errors++;
            $display("FAIL ramp4_frame_done: got %0d pulses, want 1", fd_cnt);
        end
    endtask

    task automatic test_stride2();
        int acc;
        start_test(1);
        for (int i = 0; i < 36; i++) img.push_back(i);
        gen_expected(6, 6, 3, 2, 8, 0);
        for (int i = 0; i < 36; i++) send_pix(12'(img[i]), acc);
        drain();
        checks++;
        if (obs_q.size() != 4 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL stride2_count: got %0d windows, want 4", obs_q.size());
        end else begin
            checks++;
            if (obs_q[3].row != 2 || obs_q[3].col != 2 || obs_q[3].data[7:0] !== 8'd14 || obs_q[3].data[71:64] !== 8'd28) begin
                errors++;
                $display("FAIL stride2_last: got (%0d,%0d) e00=%0d e22=%0d, want (2,2) e00=14 e22=28",
                         obs_q[3].row, obs_q[3].col, obs_q[3].data[7:0], obs_q[3].data[71:64]);
            end
        end
    endtask

    task automatic test_random_ready();
        int   acc;
        win_t ref_q [$];
        start_test(2);
        for (int i = 0; i < 64; i++) img.push_back(int'($urandom_range(0, 255)));
        gen_expected(8, 8, 3, 1, 8, 0);
        for (int i = 0; i < 64; i++) send_pix(12'(img[i]), acc);
        drain();
        ref_q = obs_q;
        obs_q.delete();
        rand_mode = 1;
        gen_expected(8, 8, 3, 1, 8, 0);
        for (int i = 0; i < 64; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                vld = '0;
                @(posedge clk);
                #1;
                step_ready();
            end
            send_pix(12'(img[i]), acc);
        end
        drain();
        rand_mode = 0;
        wready = 1'b1;
        checks++;
        if (ref_q.size() != 36 || obs_q.size() != 36 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL random_count: got %0d / %0d windows, want 36 / 36", ref_q.size(), obs_q.size());
        end else begin
            for (int i = 0; i < 36; i++) begin
                checks++;
                if (obs_q[i].row != ref_q[i].row || obs_q[i].col != ref_q[i].col || obs_q[i].data !== ref_q[i].data) begin
                    errors++;
                    $display("FAIL random_vs_ready1 #%0d: got (%0d,%0d) %h, want (%0d,%0d) %h", i,
                             obs_q[i].row, obs_q[i].col, obs_q[i].data, ref_q[i].row, ref_q[i].col, ref_q[i].data);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        int acc, acc_first, acc_last;
        int fw[9] = '{100, 101, 102, 104, 105, 106, 108, 109, 110};
        logic [299:0] want;
        start_test(0);
        for (int i = 0; i < 16; i++) img.push_back(i);
        for (int i = 0; i < 16; i++) img.push_back(100 + i);
        gen_expected(4, 4, 3, 1, 8, 0);
        gen_expected(4, 4, 3, 1, 8, 16);
        acc_first = -1;
        acc_last = -1;
        for (int i = 0; i < 32; i++) begin
            send_pix(12'(img[i]), acc);
            if (i == 0) acc_first = acc;
            if (i == 31) acc_last = acc;
        end
        drain();
        want = '0;
        for (int i = 0; i < 9; i++) want = want | (300'(fw[i]) << (i * 8));
        checks++;
        if (obs_q.size() != 8 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL b2b_count: got %0d windows, want 8", obs_q.size());
        end
        checks++;
        if (obs_q.size() < 5 || obs_q[4].data !== want) begin
            errors++;
            $display("FAIL b2b_frame2_first: got %0d windows / window 4 differs, want %h", obs_q.size(), want);
        end
        checks++;
        if (acc_last - acc_first != 31) begin
            errors++;
            $display("FAIL b2b_gapless: got %0d cycles for 32 pixels, want 31", acc_last - acc_first);
        end
        checks++;
        if (fd_cnt != 2) begin
            errors++;
            $display("FAIL b2b_frame_done: got %0d pulses, want 2", fd_cnt);
        end
    endtask

    task automatic test_reset_mid();
        int acc;
        start_test(0);
        for (int i = 0; i < 10; i++) send_pix(12'(i), acc);
        vld = '0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (wv[0] !== 1'b0 || wrow[0] != 0 || wcol[0] != 0) begin
            errors++;
            $display("FAIL reset_mid_state: got v=%b (%0d,%0d), want v=0 (0,0)", wv[0], wrow[0], wcol[0]);
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < 16; i++) img.push_back(200 + i);
        gen_expected(4, 4, 3, 1, 8, 0);
        for (int i = 0; i < 16; i++) send_pix(12'(img[i]), acc);
        drain();
        checks++;
        if (obs_q.size() != 4 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL reset_mid_count: got %0d windows, want 4", obs_q.size());
        end
    endtask

    task automatic test_k5();
        int acc;
        start_test(3);
        for (int i = 0; i < 35; i++) img.push_back(i);
        gen_expected(5, 7, 5, 1, 12, 0);
        for (int i = 0; i < 35; i++) send_pix(12'(img[i]), acc);
        drain();
        checks++;
        if (obs_q.size() != 3 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL k5_count: got %0d windows, want 3", obs_q.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (obs_q[i].row != 0 || obs_q[i].col != i) begin
                    errors++;
                    $display("FAIL k5_pos #%0d: got (%0d,%0d), want (0,%0d)", i, obs_q[i].row, obs_q[i].col, i);
                end
            end
            checks++;
            if (obs_q[2].data[24*12 +: 12] !== 12'd34) begin
                errors++;
                $display("FAIL k5_last_elem: got %0d, want 34", obs_q[2].data[24*12 +: 12]);
            end
        end
    endtask

    initial begin
        rst    = 1'b1;
        pix    = '0;
        vld    = '0;
        wready = 1'b1;
        test_reset();
        test_ramp4();
        test_stride2();
        test_random_ready();
        test_back_to_back();
        test_reset_mid();
        test_k5();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got no completion, want finish before 2 ms");
        $fatal(1);
    end

endmodule
